// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int MAX_DATA_W = 9;

    // Returns the parity bit a correct transmitter would send for this data.
    function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data, input parity_e mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with per-frame error flags, receive FIFO and saturating error counter.
//   state        | meaning
//   ST_IDLE      | line idle, waiting for a low sample on a tick
//   ST_START     | half a bit in, confirm start bit (high = glitch)
//   ST_DATA      | sample DATA_W bits mid-bit, LSB first
//   ST_PARITY    | sample and check parity bit
//   ST_STOP      | sample 1 or 2 stop bits, push frame
//   ST_WAIT_HIGH | after framing error, hold off until line returns high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              b_tick,
    input  logic              rx_in,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              overrun,
    output logic [ERR_W-1:0]  err_count,
    input  logic              err_clr
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] FULL_BIT = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(OVERSAMPLE / 2 - 1);

    logic              sync1, sync2;
    rx_state_e         state;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    parity_e           par_q;
    logic              stop2_q, stop_second, perr_q;
    logic              sample, last_stop, push, push_ferr;
    logic              fifo_full, fifo_empty, drop, err_evt;

    assign sample    = b_tick && (tick_cnt == '0);
    assign last_stop = !stop2_q || stop_second;
    assign push_ferr = !sync2;
    assign push      = (state == ST_STOP) && sample && (push_ferr || last_stop);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            // Down-counter runs on every tick; states reload it at each sample point.
            if (b_tick && tick_cnt != '0) tick_cnt <= tick_cnt - 1'b1;
            case (state)
                ST_IDLE: if (b_tick && !sync2) begin
                    state    <= ST_START;
                    tick_cnt <= HALF_BIT;
                    par_q    <= (cfg_parity == 2'b11) ? PAR_NONE : parity_e'(cfg_parity);
                    stop2_q  <= cfg_stop2;
                    perr_q   <= 1'b0;
                end
                ST_START: if (sample) begin
                    if (sync2) state <= ST_IDLE;
                    else begin
                        state    <= ST_DATA;
                        tick_cnt <= FULL_BIT;
                        bit_cnt  <= '0;
                    end
                end
                ST_DATA: if (sample) begin
                    shreg    <= {sync2, shreg[DATA_W-1:1]};
                    tick_cnt <= FULL_BIT;
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        bit_cnt     <= '0;
                        stop_second <= 1'b0;
                        state       <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: if (sample) begin
                    perr_q   <= sync2 != parity_calc(MAX_DATA_W'(shreg), par_q);
                    tick_cnt <= FULL_BIT;
                    state    <= ST_STOP;
                end
                ST_STOP: if (sample) begin
                    if (!sync2)        state <= ST_WAIT_HIGH;
                    else if (last_stop) state <= ST_IDLE;
                    else begin
                        stop_second <= 1'b1;
                        tick_cnt    <= FULL_BIT;
                    end
                end
                ST_WAIT_HIGH: if (sync2) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_ready),
        .din   ({shreg, perr_q, push_ferr}),
        .dout  ({rd_data, rd_perr, rd_ferr}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    // A full FIFO implies non-empty, so a same-cycle pop frees a slot.
    assign drop     = push && fifo_full && !rd_ready;
    assign err_evt  = drop || (push && !drop && (perr_q || push_ferr));

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            overrun <= drop;
            if (err_clr)                       err_count <= err_evt ? ERR_W'(1) : '0;
            else if (err_evt && !(&err_count)) err_count <= err_count + ERR_W'(1);
        end
    end

endmodule
